// File: rtl/uart_rx_frame_ctrl_pkg.sv
// uart_rx_frame_ctrl_pkg: frame states, bit-index and parity-type constants for the UART receiver
package uart_rx_frame_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } state_t;
    localparam logic [3:0] START_BIT = 4'd0;
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;
endpackage

// File: rtl/rx_data_sampler.sv
// rx_data_sampler: three-point majority sampling of rx_in around mid-bit
//  clk, rest (async active-low) | rx_in serial line | enable from frame FSM
//  edge_cnt, prescale from the edge/bit counter | sampled_bit majority value
//  sample_done pulses at edge_cnt == H+2 once all three samples are held
module rx_data_sampler (
    input  logic       clk,
    input  logic       rest,
    input  logic       rx_in,
    input  logic       enable,
    input  logic [4:0] edge_cnt,
    input  logic [4:0] prescale,
    output logic       sampled_bit,
    output logic       sample_done
);
    logic [4:0] h;
    logic [2:0] s;
    assign h = prescale >> 1;
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            s <= '0;
        end else if (enable) begin
            if (edge_cnt == h - 5'd1) s[0] <= rx_in;
            if (edge_cnt == h)        s[1] <= rx_in;
            if (edge_cnt == h + 5'd1) s[2] <= rx_in;
        end
    end
    assign sampled_bit = (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    assign sample_done = enable && (edge_cnt == h + 5'd2);
endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: UART receive frame FSM, LSB-first deserialiser, parity/stop checking
//  clk, rest (async active-low) | rx_in synchronised serial line (idle high)
//  prescale oversampling ratio | par_en, par_typ parity enable / odd select
//  edge_cnt, bit_cnt from the edge/bit counter | cnt_enable counter enable
//  p_data last good word | data_valid one-cycle pulse | par_err, stp_err frame errors
module uart_rx_frame_ctrl
    import uart_rx_frame_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rest,
    input  logic                  rx_in,
    input  logic [4:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic [4:0]            edge_cnt,
    input  logic [3:0]            bit_cnt,
    output logic                  cnt_enable,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);
    state_t state, nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic sampled_bit, sample_done, bit_end, frame_ok;

    rx_data_sampler u_sampler (
        .clk        (clk),
        .rest       (rest),
        .rx_in      (rx_in),
        .enable     (cnt_enable),
        .edge_cnt   (edge_cnt),
        .prescale   (prescale),
        .sampled_bit(sampled_bit),
        .sample_done(sample_done)
    );

    assign bit_end    = edge_cnt == prescale;
    assign cnt_enable = state inside {START, DATA, PARITY, STOP};
    assign frame_ok   = !par_err && !stp_err;

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) state <= IDLE;
        else       state <= nxt;
    end

    // STOP leaves on the sample point rather than bit_end so a start bit
    // directly after the stop bit is still seen from IDLE.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (!rx_in) nxt = START;
            START:   if (sample_done && sampled_bit) nxt = IDLE;
                     else if (bit_end && bit_cnt == START_BIT) nxt = DATA;
            DATA:    if (bit_end && bit_cnt == 4'(DATA_WIDTH)) nxt = par_en ? PARITY : STOP;
            PARITY:  if (bit_end) nxt = STOP;
            STOP:    if (sample_done) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            shreg      <= '0;
            p_data     <= '0;
            data_valid <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            data_valid <= state == DONE && frame_ok;
            if (state == DONE && frame_ok) p_data <= shreg;
            if (state == IDLE && !rx_in) begin
                par_err <= 1'b0;
                stp_err <= 1'b0;
            end
            if (state == DATA && sample_done) shreg <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
            if (state == PARITY && sample_done) par_err <= sampled_bit != (^shreg ^ (par_typ == PAR_ODD));
            if (state == STOP && sample_done) stp_err <= ~sampled_bit;
        end
    end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: directed frames through the frame controller with a behavioural edge/bit counter
module tb_uart_rx_frame_ctrl;
    logic       clk = 1'b0;
    logic       rest = 1'b0;
    logic       rx_in = 1'b1;
    logic [4:0] prescale = 5'd8;
    logic       par_en = 1'b0;
    logic       par_typ = 1'b0;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       cnt_enable;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    int n_chk = 0;
    int n_fail = 0;
    int vcnt = 0;
    int vbad = 0;
    logic [7:0] vdata = 8'h00;
    int v0;

    always #5 clk = ~clk;

    uart_rx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rest      (rest),
        .rx_in     (rx_in),
        .prescale  (prescale),
        .par_en    (par_en),
        .par_typ   (par_typ),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .cnt_enable(cnt_enable),
        .p_data    (p_data),
        .data_valid(data_valid),
        .par_err   (par_err),
        .stp_err   (stp_err)
    );

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == prescale) begin
            edge_cnt <= 5'd1;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    always @(negedge clk) begin
        if (data_valid) begin
            vcnt++;
            vdata = p_data;
            if (par_err || stp_err) vbad++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // gl inverts the sample taken at edge_cnt == H during data bits only
    task automatic send_bit(input logic v, input logic gl);
        for (int i = 0; i < int'(prescale); i++) begin
            rx_in = (gl && edge_cnt == (prescale >> 1) && bit_cnt >= 4'd1 && bit_cnt <= 4'd8) ? ~v : v;
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pv, input logic sv, input logic gl);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], gl);
        if (pe) send_bit(pv, 1'b0);
        send_bit(sv, 1'b0);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cnt_enable", cnt_enable, 0);
        check("rst_p_data", p_data, 0);
        check("rst_data_valid", data_valid, 0);
        check("rst_par_err", par_err, 0);
        check("rst_stp_err", stp_err, 0);
        rest = 1'b1;
        idle(4);

        v0 = vcnt;
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check("t1_valid_count", vcnt - v0, 1);
        check("t1_p_data", p_data, 8'hA5);
        check("t1_valid_data", vdata, 8'hA5);
        check("t1_par_err", par_err, 0);
        check("t1_stp_err", stp_err, 0);

        v0 = vcnt;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (12) @(negedge clk);
        check("t3_cnt_enable", cnt_enable, 0);
        check("t3_bit_cnt", bit_cnt, 0);
        check("t3_valid_count", vcnt - v0, 0);
        check("t3_p_data", p_data, 8'hA5);
        check("t3_errs", {par_err, stp_err}, 0);
        idle(8);

        par_en = 1'b1;
        par_typ = 1'b0;
        v0 = vcnt;
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(16);
        check("t2a_valid_count", vcnt - v0, 1);
        check("t2a_p_data", p_data, 8'h3C);
        check("t2a_par_err", par_err, 0);
        v0 = vcnt;
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(16);
        check("t2b_valid_count", vcnt - v0, 0);
        check("t2b_par_err", par_err, 1);
        check("t2b_stp_err", stp_err, 0);
        check("t2b_p_data", p_data, 8'h3C);

        par_en = 1'b0;
        v0 = vcnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(16);
        check("t4a_valid_count", vcnt - v0, 0);
        check("t4a_stp_err", stp_err, 1);
        check("t4a_par_err", par_err, 0);
        check("t4a_p_data", p_data, 8'h3C);
        v0 = vcnt;
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(16);
        check("t4b_valid_count", vcnt - v0, 1);
        check("t4b_p_data", p_data, 8'h0F);
        check("t4b_stp_err", stp_err, 0);

        prescale = 5'd16;
        idle(4);
        v0 = vcnt;
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(32);
        check("t5_valid_count", vcnt - v0, 1);
        check("t5_p_data", p_data, 8'hFF);
        check("t5_errs", {par_err, stp_err}, 0);

        prescale = 5'd8;
        par_en = 1'b1;
        par_typ = 1'b1;
        idle(4);
        v0 = vcnt;
        send_frame(8'h12, 1'b1, 1'b1, 1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("t6_first_valid_count", vcnt - v0, 1);
        check("t6_first_valid_data", vdata, 8'h12);
        rest = 1'b0;
        @(negedge clk);
        check("t6_rst_p_data", p_data, 0);
        check("t6_rst_data_valid", data_valid, 0);
        check("t6_rst_cnt_enable", cnt_enable, 0);
        check("t6_rst_errs", {par_err, stp_err}, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        rest = 1'b1;
        idle(40);
        check("t6_valid_count_total", vcnt - v0, 1);
        check("t6_p_data_after", p_data, 0);
        check("valid_with_error_flag", vbad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
